// File: rtl/reg_spill_ctrl_if.sv
// ============================================================================
// reg_spill_ctrl_if : control, register-file and data-memory signals of the
//                     context save/restore sequencer (REG_SPILL_CHECKSUM_EN adds cks_err)
// Rev 1.0 - initial release
// ============================================================================
`default_nettype none

interface reg_spill_ctrl_if #(
    parameter int pw = 4,
    parameter int AW = 8
);
    logic          save_req;
    logic          restore_req;
    logic          busy;
    logic          done;
    logic [pw:0]   rf_opRegAddr;
    logic [7:0]    rf_opRegData;
    logic          rf_regWrite;
    logic          rf_regSet;
    logic [7:0]    rf_writeData;
    logic          mem_req;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [7:0]    mem_wdata;
    logic          mem_ack;
    logic [7:0]    mem_rdata;
`ifdef REG_SPILL_CHECKSUM_EN
    logic          cks_err;
`endif

    modport master (
        input  save_req, restore_req, rf_opRegData, mem_ack, mem_rdata,
        output busy, done, rf_opRegAddr, rf_regWrite, rf_regSet, rf_writeData,
               mem_req, mem_we, mem_addr, mem_wdata
`ifdef REG_SPILL_CHECKSUM_EN
        , output cks_err
`endif
    );

    modport slave (
        output save_req, restore_req, rf_opRegData, mem_ack, mem_rdata,
        input  busy, done, rf_opRegAddr, rf_regWrite, rf_regSet, rf_writeData,
               mem_req, mem_we, mem_addr, mem_wdata
`ifdef REG_SPILL_CHECKSUM_EN
        , input cks_err
`endif
    );
endinterface

`default_nettype wire

// File: rtl/reg_spill_ctrl.sv
// ============================================================================
// reg_spill_ctrl : saves r0..r15 to data memory and restores them through the
//                  register file's regWrite/regSet paths. Option: REG_SPILL_CHECKSUM_EN
// Rev 1.0 - initial release
// ============================================================================
`default_nettype none

module reg_spill_ctrl #(
    parameter int            pw   = 4,
    parameter int            AW   = 8,
    parameter logic [AW-1:0] BASE = 8'hE0
) (
    input  wire logic          clk,
    input  wire logic          reset,
    reg_spill_ctrl_if.master   bus
);
    localparam int            N      = 2 ** pw;
    localparam logic [pw-1:0] c_LAST = {pw{1'b1}};

    localparam logic [2:0] c_IDLE = 3'd0;
    localparam logic [2:0] c_SAVE = 3'd1;
    localparam logic [2:0] c_RD   = 3'd2;
    localparam logic [2:0] c_LOAD = 3'd3;
    localparam logic [2:0] c_SET  = 3'd4;
    localparam logic [2:0] c_DONE = 3'd5;
`ifdef REG_SPILL_CHECKSUM_EN
    localparam logic [2:0] c_CKS  = 3'd6;
`endif

    logic [2:0]    r_state;
    logic [pw-1:0] r_index;
    logic [7:0]    r_hold;
`ifdef REG_SPILL_CHECKSUM_EN
    logic [7:0]    r_acc;
    logic [7:0]    r_stored;
    logic          r_dir;
    logic          r_cks_err;

    assign bus.cks_err = r_cks_err;
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state   <= c_IDLE;
            r_index   <= '0;
            r_hold    <= '0;
`ifdef REG_SPILL_CHECKSUM_EN
            r_acc     <= '0;
            r_stored  <= '0;
            r_dir     <= 1'b0;
            r_cks_err <= 1'b0;
`endif
        end else begin
            case (r_state)
                c_IDLE: begin
                    // save has priority; a simultaneous restore is dropped
                    if (bus.save_req) begin
                        r_state   <= c_SAVE;
                        r_index   <= '0;
`ifdef REG_SPILL_CHECKSUM_EN
                        r_acc     <= '0;
                        r_dir     <= 1'b1;
                        r_cks_err <= 1'b0;
`endif
                    end else if (bus.restore_req) begin
                        r_index   <= c_LAST;
`ifdef REG_SPILL_CHECKSUM_EN
                        r_state   <= c_CKS;
                        r_acc     <= '0;
                        r_dir     <= 1'b0;
                        r_cks_err <= 1'b0;
`else
                        r_state   <= c_RD;
`endif
                    end
                end
                c_SAVE: begin
                    if (bus.mem_ack) begin
`ifdef REG_SPILL_CHECKSUM_EN
                        r_acc <= r_acc ^ bus.rf_opRegData;
`endif
                        if (r_index == c_LAST) begin
`ifdef REG_SPILL_CHECKSUM_EN
                            r_state <= c_CKS;
`else
                            r_state <= c_DONE;
`endif
                        end else begin
                            r_index <= r_index + 1'b1;
                        end
                    end
                end
                c_RD: begin
                    if (bus.mem_ack) begin
                        r_hold  <= bus.mem_rdata;
`ifdef REG_SPILL_CHECKSUM_EN
                        r_acc   <= r_acc ^ bus.mem_rdata;
`endif
                        r_state <= c_LOAD;
                    end
                end
                c_LOAD: begin
                    if (r_index == '0) begin
                        r_state   <= c_DONE;
`ifdef REG_SPILL_CHECKSUM_EN
                        r_cks_err <= (r_acc != r_stored);
`endif
                    end else begin
                        r_state <= c_SET;
                    end
                end
                c_SET: begin
                    r_index <= r_index - 1'b1;
                    r_state <= c_RD;
                end
`ifdef REG_SPILL_CHECKSUM_EN
                c_CKS: begin
                    if (bus.mem_ack) begin
                        if (r_dir) begin
                            r_state <= c_DONE;
                        end else begin
                            r_stored <= bus.mem_rdata;
                            r_state  <= c_RD;
                        end
                    end
                end
`endif
                c_DONE:  r_state <= c_IDLE;
                default: r_state <= c_IDLE;
            endcase
        end
    end

    // Outputs are pure decodes of state, so reset forces them all to 0 at once
    always_comb begin
        bus.busy         = (r_state != c_IDLE);
        bus.done         = 1'b0;
        bus.rf_opRegAddr = '0;
        bus.rf_regWrite  = 1'b0;
        bus.rf_regSet    = 1'b0;
        bus.rf_writeData = '0;
        bus.mem_req      = 1'b0;
        bus.mem_we       = 1'b0;
        bus.mem_addr     = '0;
        bus.mem_wdata    = '0;
        case (r_state)
            c_SAVE: begin
                bus.rf_opRegAddr = {1'b0, r_index};
                bus.mem_req      = 1'b1;
                bus.mem_we       = 1'b1;
                bus.mem_addr     = BASE + AW'(r_index);
                bus.mem_wdata    = bus.rf_opRegData;
            end
            c_RD: begin
                bus.mem_req  = 1'b1;
                bus.mem_addr = BASE + AW'(r_index);
            end
            c_LOAD: begin
                bus.rf_regWrite  = 1'b1;
                bus.rf_writeData = r_hold;
            end
            c_SET: begin
                bus.rf_regSet    = 1'b1;
                bus.rf_opRegAddr = {1'b0, r_index};
            end
`ifdef REG_SPILL_CHECKSUM_EN
            c_CKS: begin
                bus.mem_req   = 1'b1;
                bus.mem_we    = r_dir;
                bus.mem_addr  = BASE + AW'(N);
                bus.mem_wdata = r_dir ? r_acc : 8'h00;
            end
`endif
            c_DONE:  bus.done = 1'b1;
            default: ;
        endcase
    end
endmodule

`default_nettype wire

// File: tb/tb_reg_spill_ctrl.sv
// ============================================================================
// tb_reg_spill_ctrl : randomized self-checking bench with register-file and
//                     memory models plus a spec-level expectation model
// Rev 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_reg_spill_ctrl;
    localparam int         PW   = 4;
    localparam int         N    = 16;
    localparam int         AW   = 8;
    localparam logic [7:0] BASE = 8'hE0;
`ifdef REG_SPILL_CHECKSUM_EN
    localparam int CKS = 1;
`else
    localparam int CKS = 0;
`endif

    logic clk   = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    reg_spill_ctrl_if #(.pw(PW), .AW(AW)) bus ();
    reg_spill_ctrl #(.pw(PW), .AW(AW), .BASE(BASE)) dut (.clk(clk), .reset(reset), .bus(bus));

    // second instance only exercises address wrap-around
    reg_spill_ctrl_if #(.pw(PW), .AW(AW)) bus2 ();
    reg_spill_ctrl #(.pw(PW), .AW(AW), .BASE(8'hF8)) dut_wrap (.clk(clk), .reset(reset), .bus(bus2));
    assign bus2.rf_opRegData = 8'h5A;
    assign bus2.mem_ack      = bus2.mem_req;
    assign bus2.mem_rdata    = 8'h00;
    logic [7:0] wrap_a8  = 8'hAA;
    logic [7:0] wrap_a15 = 8'hAA;
    always @(posedge clk) begin
        if (bus2.mem_req && bus2.rf_opRegAddr == 5'd8)  wrap_a8  <= bus2.mem_addr;
        if (bus2.mem_req && bus2.rf_opRegAddr == 5'd15) wrap_a15 <= bus2.mem_addr;
    end

    logic [7:0] rf [N];
    logic [7:0] mem [256];
    logic [7:0] load_rf [N];
    logic [7:0] load_mem [256];
    logic       load_go = 1'b0;
    int         waits = 0;
    int         wcnt, wptr, stab_err, ovl;
    logic [7:0] wlog [64];
    logic       prev_wait;
    logic [7:0] paddr, pwdata;
    logic       pwe;

    assign bus.rf_opRegData = rf[bus.rf_opRegAddr[PW-1:0]];
    assign bus.mem_ack      = bus.mem_req && (wcnt >= waits);
    assign bus.mem_rdata    = mem[bus.mem_addr];

    always @(posedge clk) begin
        if (load_go) begin
            for (int i = 0; i < 256; i++) mem[i] <= load_mem[i];
            for (int i = 0; i < N; i++)   rf[i]  <= load_rf[i];
            wptr <= 0; stab_err <= 0; ovl <= 0; wcnt <= 0; prev_wait <= 1'b0;
        end else begin
            if (bus.mem_req && bus.mem_ack && bus.mem_we) begin
                mem[bus.mem_addr] <= bus.mem_wdata;
                if (wptr < 64) wlog[wptr[5:0]] <= bus.mem_addr;
                wptr <= wptr + 1;
            end
            if (bus.rf_regWrite) rf[0] <= bus.rf_writeData;
            if (bus.rf_regSet)   rf[bus.rf_opRegAddr[PW-1:0]] <= rf[0];
            if (bus.rf_regWrite && bus.rf_regSet) ovl <= ovl + 1;
            if (prev_wait && (!bus.mem_req || bus.mem_addr != paddr ||
                              bus.mem_wdata != pwdata || bus.mem_we != pwe))
                stab_err <= stab_err + 1;
            prev_wait <= bus.mem_req && !bus.mem_ack;
            paddr     <= bus.mem_addr;
            pwdata    <= bus.mem_wdata;
            pwe       <= bus.mem_we;
            wcnt      <= (bus.mem_req && !bus.mem_ack) ? wcnt + 1 : 0;
        end
    end

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic preload();
        @(negedge clk); load_go = 1'b1;
        @(negedge clk); load_go = 1'b0;
    endtask

    task automatic randomize_loads();
        for (int i = 0; i < 256; i++) load_mem[i] = 8'($urandom);
        for (int i = 0; i < N; i++)   load_rf[i]  = 8'($urandom);
    endtask

    function automatic logic [7:0] xor_rf();
        logic [7:0] x = 8'h00;
        for (int i = 0; i < N; i++) x ^= load_rf[i];
        return x;
    endfunction

    function automatic logic [7:0] xor_mem();
        logic [7:0] x = 8'h00;
        for (int i = 0; i < N; i++) x ^= load_mem[8'(BASE + i)];
        return x;
    endfunction

    task automatic do_op(input bit sv, input bit rs, input int inject,
                         output int lat_o, output logic cks_o);
        int busy_bad = 0;
        int l;
        @(negedge clk); bus.save_req = sv; bus.restore_req = rs;
        @(posedge clk); #1; bus.save_req = 1'b0; bus.restore_req = 1'b0;
        l = 1;
        while (bus.done !== 1'b1 && l < 3000) begin
            if (bus.busy !== 1'b1) busy_bad++;
            bus.restore_req = (l == inject);
            @(posedge clk); #1; l++;
        end
        bus.restore_req = 1'b0;
        check_val("busy_in_done", bus.busy, 1);
        check_val("busy_during_op", busy_bad, 0);
`ifdef REG_SPILL_CHECKSUM_EN
        cks_o = bus.cks_err;
`else
        cks_o = 1'b0;
`endif
        lat_o = l;
        @(posedge clk); #1;
        check_val("done_single_pulse", bus.done, 0);
        check_val("busy_after_done", bus.busy, 0);
    endtask

    task automatic check_save(input int w, input int lat);
        check_val("save_latency", lat, N * (w + 1) + 1 + CKS * (w + 1));
        check_val("save_write_count", wptr, N + CKS);
        check_val("save_stable_while_wait", stab_err, 0);
        for (int i = 0; i < N + CKS; i++) check_val("save_write_order", wlog[i], 8'(BASE + i));
        for (int i = 0; i < N; i++) begin
            check_val("save_mem_data", mem[8'(BASE + i)], load_rf[i]);
            check_val("save_rf_untouched", rf[i], load_rf[i]);
        end
`ifdef REG_SPILL_CHECKSUM_EN
        check_val("save_checksum_word", mem[8'(BASE + N)], xor_rf());
`endif
    endtask

    task automatic check_restore(input int w, input int lat, input logic cks);
        check_val("restore_latency", lat, N * (w + 1) + 2 * N + CKS * (w + 1));
        check_val("restore_no_mem_writes", wptr, 0);
        check_val("restore_no_overlap", ovl, 0);
        check_val("restore_stable_while_wait", stab_err, 0);
        for (int i = 0; i < N; i++) check_val("restore_rf_data", rf[i], load_mem[8'(BASE + i)]);
`ifdef REG_SPILL_CHECKSUM_EN
        check_val("restore_cks_err", cks, xor_mem() != load_mem[8'(BASE + N)]);
`else
        check_val("restore_cks_err_absent", cks, 0);
`endif
    endtask

    function automatic logic outputs_any();
        return |{bus.busy, bus.done, bus.rf_regWrite, bus.rf_regSet, bus.mem_req, bus.mem_we,
                 bus.mem_addr, bus.mem_wdata, bus.rf_opRegAddr, bus.rf_writeData};
    endfunction

    initial begin
        int   lat, dcnt;
        logic cks;
        bit   op;
        bus.save_req = 1'b0; bus.restore_req = 1'b0;
        bus2.save_req = 1'b0; bus2.restore_req = 1'b0;
        randomize_loads();
        repeat (2) @(posedge clk);
        #1;
        check_val("reset_outputs_zero", outputs_any(), 0);
        @(negedge clk); reset = 1'b1;
        preload();

        // directed save, zero-wait, wrap-instance started alongside
        for (int i = 0; i < N; i++) load_rf[i] = 8'(8'h10 + i);
        waits = 0; preload();
        bus2.save_req = 1'b1;
        do_op(1'b1, 1'b0, 0, lat, cks);
        bus2.save_req = 1'b0;
        check_save(0, lat);
        check_val("wrap_addr_r8", wrap_a8, 8'h00);
        check_val("wrap_addr_r15", wrap_a15, 8'h07);

        // directed restore, cleared register file
        for (int i = 0; i < N; i++) begin load_mem[8'(BASE + i)] = 8'(8'hA0 + i); load_rf[i] = 8'h00; end
        preload();
        do_op(1'b0, 1'b1, 0, lat, cks);
        check_restore(0, lat, cks);

        // both requests together plus restore pulsed mid-save: only the save runs
        randomize_loads(); preload();
        do_op(1'b1, 1'b1, 5, lat, cks);
        check_save(0, lat);
        repeat (3) @(posedge clk);
        #1;
        check_val("idle_after_ignored_restore", bus.busy, 0);

        // three wait cycles per transfer
        randomize_loads(); waits = 3; preload();
        do_op(1'b1, 1'b0, 0, lat, cks);
        check_save(3, lat);

        // randomized operations
        for (int k = 0; k < 8; k++) begin
            randomize_loads();
            waits = $urandom_range(0, 3);
            op = 1'($urandom);
            preload();
            do_op(op, !op, 0, lat, cks);
            if (op) check_save(waits, lat);
            else    check_restore(waits, lat, cks);
        end

`ifdef REG_SPILL_CHECKSUM_EN
        // save, corrupt one saved register, restore -> error; clean copy -> no error
        randomize_loads(); waits = 0; preload();
        do_op(1'b1, 1'b0, 0, lat, cks);
        for (int i = 0; i < 256; i++) load_mem[i] = mem[i];
        for (int i = 0; i < N; i++)   load_rf[i]  = 8'h00;
        load_mem[8'(BASE + 5)] ^= 8'h01;
        preload();
        do_op(1'b0, 1'b1, 0, lat, cks);
        check_val("cks_err_corrupted", cks, 1);
        load_mem[8'(BASE + 5)] ^= 8'h01;
        preload();
        do_op(1'b0, 1'b1, 0, lat, cks);
        check_val("cks_err_clean", cks, 0);
`endif

        // asynchronous reset in cycle 20 of a restore
        randomize_loads(); waits = 0; preload();
        @(negedge clk); bus.restore_req = 1'b1;
        @(posedge clk); #1; bus.restore_req = 1'b0;
        dcnt = 0;
        repeat (19) begin @(posedge clk); #1; if (bus.done === 1'b1) dcnt++; end
        check_val("busy_before_reset", bus.busy, 1);
        #2 reset = 1'b0;
        #1;
        check_val("async_reset_outputs_zero", outputs_any(), 0);
        repeat (3) begin @(posedge clk); #1; if (bus.done !== 1'b0) dcnt++; end
        check_val("no_done_on_abort", dcnt, 0);
        @(negedge clk); reset = 1'b1;

        randomize_loads(); preload();
        do_op(1'b1, 1'b0, 0, lat, cks);
        check_save(0, lat);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

`default_nettype wire

// File: doc/reg_spill_ctrl.md
Name: reg_spill_ctrl

Overview:
Context save/restore sequencer for the 16-entry accumulator register file. On `save_req` it copies r0..r15 to a data-memory save area. On `restore_req` it reloads the registers, using only the register file's native write paths: `regWrite` loads r0 from `writeData`, and `regSet` copies r0 into rN. It sits between the core control unit, the register file ports and the data-memory request port. The core stalls while `busy` is high.

Parameters:
- pw, 4, register pointer width; number of registers N = 2**pw
- AW, 8, data-memory address width
- BASE, 8'hE0, first address of the save area; register i lives at BASE+i

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-low reset
- save_req  in  1  start a save; sampled in IDLE only
- restore_req  in  1  start a restore; sampled in IDLE only
- busy  out  1  high from the cycle after acceptance until DONE inclusive
- done  out  1  single-cycle pulse on completion
- rf_opRegAddr  out  pw+1  operand pointer driven to the register file; upper bit always 0
- rf_opRegData  in  8  register file read data for `rf_opRegAddr`
- rf_regWrite  out  1  load r0 from `rf_writeData`
- rf_regSet  out  1  copy r0 into r[`rf_opRegAddr`]
- rf_writeData  out  8  data for r0 load
- mem_req  out  1  memory request, held until ack
- mem_we  out  1  1 = write, 0 = read; valid while `mem_req` is high
- mem_addr  out  AW  BASE+i, modulo 2**AW
- mem_wdata  out  8  write data
- mem_ack  in  1  transfer completes in a cycle where `mem_req` and `mem_ack` are both high; `mem_rdata` is valid in that cycle
- mem_rdata  in  8  read data

Behaviour:
- Reset (asynchronous, `reset` low):
  - state = IDLE, index = 0.
  - All outputs 0, including `mem_req`, `rf_regWrite`, `rf_regSet` and `done`.
  - Reset mid-operation aborts immediately; no `done` pulse; register file and memory contents are left partial.
- States: IDLE, SAVE, RD, LOAD, SET, DONE.
- IDLE:
  - `save_req` → SAVE with index = 0.
  - else `restore_req` → RD with index = N-1.
  - Both asserted together: save wins; `restore_req` is dropped, not queued.
  - Requests outside IDLE are ignored.
- SAVE:
  - `rf_opRegAddr` = index; `mem_req` = 1, `mem_we` = 1.
  - `mem_wdata` = `rf_opRegData`, taken combinationally; the register file is quiescent while busy, so it is stable.
  - On ack with index == N-1 → DONE; otherwise index+1 and stay in SAVE.
- RD:
  - `mem_req` = 1, `mem_we` = 0, `mem_addr` = BASE+index.
  - On ack, capture `mem_rdata` into the hold register → LOAD.
- LOAD:
  - `rf_regWrite` = 1 for one cycle; `rf_writeData` = hold register.
  - index == 0 → DONE; otherwise → SET.
- SET:
  - `rf_regSet` = 1 for one cycle; `rf_opRegAddr` = index.
  - Then index-1 → RD.
- Restore order is r15 down to r1, then r0 last, so the final r0 value is the saved r0.
- DONE: `done` = 1 for one cycle → IDLE. `busy` falls in the cycle after DONE.
- Output exclusivity:
  - `rf_regWrite` and `rf_regSet` are never high together.
  - Both are 0 outside LOAD and SET.
  - `mem_req` is 0 outside SAVE and RD.
- Latency with zero-wait memory (ack in the first cycle of a request):
  - Save = N cycles + 1 DONE cycle (17 for N = 16).
  - Restore = 3(N-1) + 2 + 1 (48 for N = 16).
  - Each memory wait cycle adds one cycle.
- `mem_addr` wraps modulo 2**AW. With BASE = 8'hF8 and N = 16, register 8 maps to address 8'h00.

Optional Feature:
Macro REG_SPILL_CHECKSUM_EN.
- Defined:
  - Adds state CKS plus output `cks_err` (1 bit, reset 0).
  - Save accumulates an 8-bit XOR of all written data. After r15, CKS writes the XOR to BASE+N, then goes to DONE.
  - Restore reads BASE+N first in CKS, then continues with r15..r0 while accumulating XOR.
  - At DONE, `cks_err` = (accumulated XOR != stored checksum). It holds until the next accepted request, which clears it.
  - Latency grows by one memory transfer per operation.
- Undefined:
  - No CKS state and no `cks_err` port.
  - Behaviour exactly as above.

Test Plan:
- Save: preload r0..r15 = 8'h10+i; pulse `save_req`; zero-wait memory → writes BASE+i = 8'h10+i in index order, `done` at cycle 17, `busy` high throughout.
- Restore: memory BASE+i = 8'hA0+i, register file cleared; pulse `restore_req` → r1..r15 = 8'hA1..8'hAF and r0 = 8'hA0 afterward, `done` at cycle 48; `rf_regWrite`/`rf_regSet` never overlap.
- Simultaneous `save_req` and `restore_req` in IDLE → only the save runs; `restore_req` pulsed while busy → no effect.
- Memory ack delayed 3 cycles per transfer → `mem_req`, `mem_addr` and `mem_wdata` held stable until ack; save completes at cycle 16×4+1 = 65.
- Assert `reset` low at cycle 20 of a restore → all outputs 0 asynchronously, state IDLE, no `done`; a new save after release runs normally.
- With REG_SPILL_CHECKSUM_EN: save, corrupt memory at BASE+5, restore → `cks_err` = 1 at DONE; repeat without corruption → `cks_err` = 0.
